// File: rtl/iic_init_seq.sv
// Register-initialisation sequencer: walks a table of {reg_addr, data}
// entries held in an external ROM and issues one I2C write per entry.
// A NACKed write is re-sent, up to MAX_RETRY extra times.
// A missing wr_done ends the walk with an error after TIMEOUT_CYC cycles.
// A 16'hFFFF register address is a pause marker: it waits data*256
// cycles and issues no write.
module iic_init_seq #(
    parameter logic [7:0]  DEV_ID      = 8'h78,
    parameter logic        ADDR_MODE   = 1'b1,
    parameter int          MAX_RETRY   = 3,
    parameter logic [15:0] GAP_CYC     = 16'd500,
    parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  tbl_len,
    output logic [7:0]  tbl_addr,
    input  logic [23:0] tbl_rdata,
    output logic        w_req,
    output logic [7:0]  device_id,
    output logic [15:0] reg_addr,
    output logic        addr_mode,
    output logic [7:0]  wr_data,
    output logic [5:0]  w_num,
    input  logic        wr_done,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_idx
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_LOAD  = 4'd2,
        S_REQ   = 4'd3,
        S_WAIT  = 4'd4,
        S_GAP   = 4'd5,
        S_DELAY = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_idx;
    logic [7:0]  r_len;
    logic [15:0] r_reg_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_retry_cnt;
    logic        r_retry_pend;
    logic [19:0] r_cnt;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_err_idx;

    logic [19:0] w_cnt_inc;
    logic [7:0]  w_idx_inc;
    logic        w_gap_end;
    logic        w_delay_end;
    logic        w_timeout;
    logic        w_retry_ok;
    logic        w_fail;

    // One shared counter serves GAP, DELAY and the WAIT timeout; it
    // restarts from zero on every state change, so each state counts
    // its own occupancy from 0.
    assign w_cnt_inc   = r_cnt + 20'd1;
    assign w_idx_inc   = r_idx + 8'd1;
    assign w_gap_end   = (w_cnt_inc >= {4'd0, GAP_CYC});
    assign w_delay_end = (w_cnt_inc >= {4'd0, r_wr_data, 8'd0});
    assign w_timeout   = (r_cnt == TIMEOUT_CYC - 20'd1);
    assign w_retry_ok  = (r_retry_cnt < LP_MAX_RETRY);
    // The only WAIT->IDLE transitions are exhausted retries and timeout.
    assign w_fail      = (r_state == S_WAIT) && (w_state_nxt == S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (tbl_len == 8'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_state_nxt = (tbl_rdata[23:8] == 16'hFFFF) ? S_DELAY : S_REQ;
            end
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (wr_done) begin
                    if (!ack || w_retry_ok) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = r_retry_pend ? S_REQ : S_NEXT;
                end
            end
            S_DELAY: begin
                if (w_delay_end) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_nxt = (w_idx_inc == r_len) ? S_DONE : S_FETCH;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the held registers.
    always_comb begin
        w_req     = (r_state == S_REQ);
        busy      = (r_state != S_IDLE) && (r_state != S_DONE);
        done      = r_done;
        err       = r_err;
        err_idx   = r_err_idx;
        tbl_addr  = r_idx;
        reg_addr  = r_reg_addr;
        wr_data   = r_wr_data;
        device_id = DEV_ID;
        addr_mode = ADDR_MODE;
        w_num     = 6'd1;
    end

    // Entry index, latched entry, retry bookkeeping, counters and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 8'd0;
            r_len        <= 8'd0;
            r_reg_addr   <= 16'd0;
            r_wr_data    <= 8'd0;
            r_retry_cnt  <= 8'd0;
            r_retry_pend <= 1'b0;
            r_cnt        <= 20'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_idx    <= 8'd0;
        end else begin
            r_done <= (r_state == S_DONE);
            r_cnt  <= (w_state_nxt != r_state) ? 20'd0 : w_cnt_inc;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= 8'd0;
                        r_len <= tbl_len;
                        r_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_reg_addr   <= tbl_rdata[23:8];
                    r_wr_data    <= tbl_rdata[7:0];
                    r_retry_cnt  <= 8'd0;
                    r_retry_pend <= 1'b0;
                end
                S_WAIT: begin
                    if (wr_done && ack && w_retry_ok) begin
                        r_retry_cnt  <= r_retry_cnt + 8'd1;
                        r_retry_pend <= 1'b1;
                    end else if (w_fail) begin
                        r_err     <= 1'b1;
                        r_err_idx <= r_idx;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_retry_pend <= 1'b0;
                    end
                end
                S_NEXT: r_idx <= w_idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_init_seq.sv
// Bench for iic_init_seq: ROM model, I2C controller responder, directed
// vector table, hand-written corner sequences and randomized tables
// checked against a table-level reference model.
module tb_iic_init_seq;

    localparam int          MAXR = 3;
    localparam logic [15:0] GAP  = 16'd20;
    localparam logic [19:0] TMO  = 20'd400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tbl_len = 8'd0;
    logic [7:0]  tbl_addr;
    logic [23:0] tbl_rdata = 24'd0;
    logic        w_req;
    logic [7:0]  device_id;
    logic [15:0] reg_addr;
    logic        addr_mode;
    logic [7:0]  wr_data;
    logic [5:0]  w_num;
    logic        wr_done = 1'b0;
    logic        ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_idx;

    iic_init_seq #(
        .DEV_ID(8'h78), .ADDR_MODE(1'b1), .MAX_RETRY(MAXR),
        .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tbl_len(tbl_len),
        .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata), .w_req(w_req),
        .device_id(device_id), .reg_addr(reg_addr), .addr_mode(addr_mode),
        .wr_data(wr_data), .w_num(w_num), .wr_done(wr_done), .ack(ack),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus-side state (written by the main initial)
    logic [23:0] rom [256];
    int          nack_plan [256];
    int          lat = 5;       // 0 means the controller never answers
    int          gen_tb = 0;
    int          start_cyc = 0;

    // Synchronous ROM: data valid the cycle after the address is presented.
    always @(posedge clk) tbl_rdata <= rom[tbl_addr];

    // ---------------- responder / monitor state
    int          gen_rsp = 0;
    int          attempts [256];
    bit          rsp_pend = 0;
    int          rsp_cnt = 0;
    bit          rsp_ack = 0;
    logic [15:0] obs_a [$];
    logic [7:0]  obs_d [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          wreq_cyc = 0;
    int          err_cyc = 0;
    int          chg_cyc [$];
    int          chg_val [$];
    logic [7:0]  prev_addr = 8'd0;
    bit          wreq_prev = 0;
    bit          err_prev = 0;
    int          wreq_long = 0;
    int          busy_viol = 0;

    // Controller model and output monitor, sampled 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        wr_done = 1'b0;
        ack = 1'b0;
        if (gen_rsp != gen_tb) begin
            gen_rsp = gen_tb;
            for (int i = 0; i < 256; i++) attempts[i] = 0;
            rsp_pend = 0;
        end
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                wr_done = 1'b1;
                ack = rsp_ack;
                rsp_pend = 0;
            end else begin
                rsp_cnt = rsp_cnt - 1;
            end
        end
        if (w_req === 1'b1) begin
            obs_a.push_back(reg_addr);
            obs_d.push_back(wr_data);
            wreq_cyc = cyc;
            if (wreq_prev) wreq_long++;
            attempts[tbl_addr] = attempts[tbl_addr] + 1;
            if (lat > 0) begin
                rsp_pend = 1;
                rsp_cnt = lat - 1;
                rsp_ack = (attempts[tbl_addr] <= nack_plan[tbl_addr]);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err === 1'b1 && !err_prev) begin
            err_cyc = cyc;
            if (busy === 1'b1) busy_viol++;
        end
        if (tbl_addr !== prev_addr) begin
            chg_cyc.push_back(cyc);
            chg_val.push_back(int'(tbl_addr));
        end
        prev_addr = tbl_addr;
        wreq_prev = (w_req === 1'b1);
        err_prev = (err === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model: expected writes from the table rules
    logic [15:0] exp_a [$];
    logic [7:0]  exp_d [$];
    bit          exp_ok;
    int          exp_idx;

    function automatic void model(input int len);
        int tries;
        exp_a.delete();
        exp_d.delete();
        exp_ok = 1;
        exp_idx = 0;
        for (int i = 0; i < len; i++) begin
            if (rom[i][23:8] == 16'hFFFF) continue;
            tries = (nack_plan[i] > MAXR) ? MAXR + 1 : nack_plan[i] + 1;
            for (int k = 0; k < tries; k++) begin
                exp_a.push_back(rom[i][23:8]);
                exp_d.push_back(rom[i][7:0]);
            end
            if (nack_plan[i] > MAXR) begin
                exp_ok = 0;
                exp_idx = i;
                return;
            end
        end
    endfunction

    task automatic set_normal(input int len);
        for (int i = 0; i < 256; i++) begin
            rom[i] = {16'h3000 + 16'(i), 8'h10 + 8'(i)};
            nack_plan[i] = 0;
        end
    endtask

    task automatic run_txn(input int len, input int budget, output int ob, output int db);
        bit fin;
        ob = obs_a.size();
        db = done_cnt;
        fin = 0;
        @(negedge clk);
        gen_tb++;
        start = 1'b1;
        tbl_len = 8'(len);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cnt != db || err === 1'b1) begin
                fin = 1;
                break;
            end
        end
        if (!fin) chk("txn_finished", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_txn(input string tag, input int len, input int ob, input int db);
        int nm;
        model(len);
        chk({tag, "_nwr"}, 32'(obs_a.size() - ob), 32'(exp_a.size()));
        nm = 0;
        for (int i = 0; i < exp_a.size() && ob + i < obs_a.size(); i++) begin
            if (obs_a[ob + i] !== exp_a[i] || obs_d[ob + i] !== exp_d[i]) nm++;
        end
        chk({tag, "_content"}, 32'(nm), 32'd0);
        chk({tag, "_done"}, 32'(done_cnt - db), exp_ok ? 32'd1 : 32'd0);
        chk({tag, "_err"}, 32'(err), exp_ok ? 32'd0 : 32'd1);
        if (!exp_ok) chk({tag, "_err_idx"}, 32'(err_idx), 32'(exp_idx));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int len;
        int n0, n1, n2, n3;
        int lat;
        int exp_wr;
        int exp_done;
        int exp_err;
        int exp_idx;
    } vec_t;

    vec_t vt [6];

    initial begin
        int ob, db, base, c1, c2, pause, nb, len, t;

        vt[0] = '{3, 0, 0, 0, 0, 50, 3, 1, 0, 0};  // plain walk
        vt[1] = '{3, 0, 1, 0, 0, 7,  4, 1, 0, 0};  // entry 1 NACK once
        vt[2] = '{3, 0, 2, 0, 0, 9,  5, 1, 0, 0};  // entry 1 NACK twice
        vt[3] = '{3, 0, 0, 9, 0, 5,  6, 0, 1, 2};  // entry 2 always NACKs
        vt[4] = '{1, 3, 0, 0, 0, 3,  4, 1, 0, 0};  // last allowed retry
        vt[5] = '{4, 1, 0, 0, 9, 4,  8, 0, 1, 3};  // failure on last entry

        set_normal(256);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state and constant outputs
        chk("rst_w_req", 32'(w_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("device_id", 32'(device_id), 32'h78);
        chk("addr_mode", 32'(addr_mode), 32'd1);
        chk("w_num", 32'(w_num), 32'd1);

        // directed vector table
        foreach (vt[v]) begin
            set_normal(256);
            nack_plan[0] = vt[v].n0;
            nack_plan[1] = vt[v].n1;
            nack_plan[2] = vt[v].n2;
            nack_plan[3] = vt[v].n3;
            lat = vt[v].lat;
            run_txn(vt[v].len, 5000, ob, db);
            chk($sformatf("vec%0d_nwr", v), 32'(obs_a.size() - ob), 32'(vt[v].exp_wr));
            chk($sformatf("vec%0d_done", v), 32'(done_cnt - db), 32'(vt[v].exp_done));
            chk($sformatf("vec%0d_err", v), 32'(err), 32'(vt[v].exp_err));
            if (vt[v].exp_err != 0)
                chk($sformatf("vec%0d_err_idx", v), 32'(err_idx), 32'(vt[v].exp_idx));
            check_txn($sformatf("vec%0d", v), vt[v].len, ob, db);
        end

        // empty table: done two cycles after start, no write
        run_txn(0, 50, ob, db);
        chk("len0_nwr", 32'(obs_a.size() - ob), 32'd0);
        chk("len0_done", 32'(done_cnt - db), 32'd1);
        chk("len0_latency", 32'(done_cyc - start_cyc), 32'd2);

        // start while busy is ignored
        set_normal(256);
        lat = 20;
        ob = obs_a.size();
        db = done_cnt;
        @(negedge clk);
        gen_tb++;
        start = 1'b1;
        tbl_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        tbl_len = 8'd7;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000 && done_cnt == db; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_txn("restart", 3, ob, db);

        // pause marker {FFFF, 4}: no write and a 1024-cycle pause
        set_normal(256);
        rom[1] = {16'hFFFF, 8'd4};
        lat = 5;
        base = chg_cyc.size();
        run_txn(3, 5000, ob, db);
        check_txn("delay", 3, ob, db);
        c1 = -1;
        c2 = -1;
        for (int i = base; i < chg_cyc.size(); i++) begin
            if (chg_val[i] == 1 && c1 < 0) c1 = chg_cyc[i];
            if (chg_val[i] == 2 && c2 < 0) c2 = chg_cyc[i];
        end
        // FETCH, LOAD and NEXT add three fixed cycles around the pause
        pause = c2 - c1 - 3;
        chk("delay_pause_in_range", 32'(pause >= 1021 && pause <= 1027), 32'd1);

        // no wr_done: timeout error, single write, no retry
        set_normal(256);
        lat = 0;
        run_txn(2, 3000, ob, db);
        chk("tmo_nwr", 32'(obs_a.size() - ob), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_err_idx", 32'(err_idx), 32'd0);
        chk("tmo_done", 32'(done_cnt - db), 32'd0);
        chk("tmo_latency_in_range",
            32'((err_cyc - wreq_cyc) >= 400 && (err_cyc - wreq_cyc) <= 402), 32'd1);

        // reset during WAIT, then the controller's late wr_done arrives
        set_normal(256);
        lat = 50;
        ob = obs_a.size();
        @(negedge clk);
        gen_tb++;
        start = 1'b1;
        tbl_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && obs_a.size() == ob; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nb = obs_a.size();
        repeat (80) @(negedge clk);
        chk("rstw_nwr", 32'(obs_a.size() - nb), 32'd0);
        chk("rstw_outputs",
            {8'd0, 8'(busy), 8'(done | err | w_req), err_idx | tbl_addr | wr_data},
            32'd0);
        chk("rstw_reg_addr", 32'(reg_addr), 32'd0);

        // randomized tables against the reference model
        for (t = 0; t < 12; t++) begin
            len = $urandom_range(1, 5);
            set_normal(256);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    rom[i] = {16'hFFFF, 8'($urandom_range(0, 1))};
                end else begin
                    rom[i] = {16'($urandom), 8'($urandom)};
                    if (rom[i][23:8] == 16'hFFFF) rom[i][23:8] = 16'hFFFE;
                end
                nack_plan[i] = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 5);
            end
            lat = $urandom_range(1, 30);
            run_txn(len, 6000, ob, db);
            check_txn($sformatf("rnd%0d", t), len, ob, db);
        end

        chk("w_req_single_cycle", 32'(wreq_long), 32'd0);
        chk("busy_low_with_err", 32'(busy_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
